mem_req_sequencer: RTL

//  Upstream command stage for the 256-byte, byte-addressed MEMORY block.

---
 rtl/mem_seq_pkg.sv | 21 ++
 rtl/mem_req_fifo.sv | 57 +++++
 rtl/mem_req_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the MEMORY request sequencer.
// Widths are fixed by the downstream 256-byte MEMORY block.
package mem_seq_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      RESP    = 2'd3
   } state_t;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO: DEPTH x req_t, registered occupancy count, full/empty flags.
// Synchronous active-low reset flushes pointers and count; storage is not cleared.
module mem_req_fifo
   import mem_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push_i,
   input  req_t din_i,
   input  logic pop_i,
   output req_t head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   req_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy update; push and pop together leave the count unchanged.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage, written only on an accepted push.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/mem_req_sequencer.sv
// Upstream command stage for the 256-byte MEMORY block: queues client
// read/write requests, drives the registered memory pins one request at a
// time and returns read data on a valid/ready response port.
// Optional feature: define MEM_SEQ_ALIGN_CHECK_EN to drop misaligned
// requests (REQ_ADDR[1:0] != 0) and pulse ERR for one cycle.
module mem_req_sequencer
   import mem_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 4
)
(
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_RW,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [DATA_W-1:0] REQ_DATA,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_DATA,
   output logic              ERR,
   output logic [ADDR_W-1:0] M_ADDR,
   output logic [DATA_W-1:0] M_DIN,
   output logic              M_RW,
   output logic              M_VALID,
   input  logic [DATA_W-1:0] M_DOUT
);

   state_t            state_q, state_d;
   logic              ready_en_q;
   logic              accept;
   logic              enq;
   logic              pop;
   logic              full;
   logic              empty;
   req_t              req_in;
   req_t              head;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_din_q, m_din_d;
   logic              m_rw_q, m_rw_d;
   logic              m_valid_q, m_valid_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   // ready_en_q holds REQ_READY low while reset is applied.
   assign REQ_READY = ready_en_q && !full;
   assign accept    = REQ_VALID && REQ_READY;
   assign req_in    = '{rw: REQ_RW, addr: REQ_ADDR, data: REQ_DATA};

`ifdef MEM_SEQ_ALIGN_CHECK_EN
   logic misalign;
   logic err_q;

   assign misalign = (REQ_ADDR[1:0] != 2'b00);
   // Misaligned requests complete the handshake but never reach the FIFO.
   assign enq      = accept && !misalign;
   assign ERR      = err_q;

   // One-cycle error pulse following a dropped request.
   always_ff @(posedge CLK) begin
      if (!RESET_N) err_q <= 1'b0;
      else          err_q <= accept && misalign;
   end
`else
   assign enq = accept;
   assign ERR = 1'b0;
`endif

   mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RESET_N),
      .push_i  (enq),
      .din_i   (req_in),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
   );

   // Next-state logic: issue from IDLE, chain after writes, capture and hold reads.
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      m_valid_d   = 1'b0;
      m_addr_d    = m_addr_q;
      m_din_d     = m_din_q;
      m_rw_d      = m_rw_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               m_addr_d  = head.addr;
               m_din_d   = head.data;
               m_rw_d    = head.rw;
               m_valid_d = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            // m_rw_q is the request MEMORY samples at this edge.
            if (m_rw_q) begin
               if (!empty) begin
                  pop       = 1'b1;
                  m_addr_d  = head.addr;
                  m_din_d   = head.data;
                  m_rw_d    = head.rw;
                  m_valid_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            rsp_data_d  = M_DOUT;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (RSP_READY) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset discards any pending response.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q     <= IDLE;
         ready_en_q  <= 1'b0;
         m_addr_q    <= '0;
         m_din_q     <= '0;
         m_rw_q      <= 1'b0;
         m_valid_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ready_en_q  <= 1'b1;
         m_addr_q    <= m_addr_d;
         m_din_q     <= m_din_d;
         m_rw_q      <= m_rw_d;
         m_valid_q   <= m_valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign M_ADDR    = m_addr_q;
   assign M_DIN     = m_din_q;
   assign M_RW      = m_rw_q;
   assign M_VALID   = m_valid_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_DATA  = rsp_data_q;

endmodule
